// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read, two-write register file with same-cycle write-to-read bypass.
// Optional RAW busy scoreboard is compiled in when REGFILE_SCOREBOARD_EN is defined.
module regfile_mp #(
    parameter int               WIDTH   = 32,
    parameter int               AW      = 5,
    parameter int               NRD     = 4,
    parameter logic [WIDTH-1:0] GP_INIT = 32'h00001800,
    parameter logic [WIDTH-1:0] SP_INIT = 32'h00002ffe
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [WIDTH-1:0]     wdata0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [WIDTH-1:0]     wdata1,
    input  logic [1:0]           iss_vld,
    input  logic [AW-1:0]        iss_rd0,
    input  logic [AW-1:0]        iss_rd1,
    input  logic                 flush
);

    localparam int NREG = 2 ** AW;

    logic [WIDTH-1:0] regs [NREG];
    logic [AW-1:0]    ra;

    // Port 1 is assigned last so a same-address collision keeps the younger slot's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                if (i == 28)
                    regs[i] <= GP_INIT;
                else if (i == 29)
                    regs[i] <= SP_INIT;
                else
                    regs[i] <= '0;
            end
        end else begin
            if (we0 && waddr0 != '0)
                regs[waddr0] <= wdata0;
            if (we1 && waddr1 != '0)
                regs[waddr1] <= wdata1;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Sets are applied after clears so an issuing instruction beats an older writeback.
    always_comb begin
        busy_nxt = busy;
        if (we0)
            busy_nxt[waddr0] = 1'b0;
        if (we1)
            busy_nxt[waddr1] = 1'b0;
        if (iss_vld[0])
            busy_nxt[iss_rd0] = 1'b1;
        if (iss_vld[1])
            busy_nxt[iss_rd1] = 1'b1;
        if (flush)
            busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end
`else
    logic unused_sb;
    assign unused_sb = ^{iss_vld, iss_rd0, iss_rd1, flush};
`endif

    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = raddr[k*AW +: AW];
            if (rst_n && ra != '0) begin
                if (we1 && waddr1 == ra)
                    rdata[k*WIDTH +: WIDTH] = wdata1;
                else if (we0 && waddr0 == ra)
                    rdata[k*WIDTH +: WIDTH] = wdata0;
                else
                    rdata[k*WIDTH +: WIDTH] = regs[ra];
`ifdef REGFILE_SCOREBOARD_EN
                // A write in flight is already bypassed, so it no longer blocks the reader.
                rbusy[k] = busy[ra] && !(we0 && waddr0 == ra) && !(we1 && waddr1 == ra);
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven directed vectors plus randomized run against a behavioural model.
// Expected busy flags follow REGFILE_SCOREBOARD_EN; without it rbusy must stay 0.
module tb_regfile_mp;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 4;
    localparam int NREG  = 32;
`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rbusy;
    logic                 we0, we1;
    logic [AW-1:0]        waddr0, waddr1;
    logic [WIDTH-1:0]     wdata0, wdata1;
    logic [1:0]           iss_vld;
    logic [AW-1:0]        iss_rd0, iss_rd1;
    logic                 flush;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] m_reg  [NREG];
    bit               m_busy [NREG];

    typedef struct packed {
        logic                 we0;
        logic [AW-1:0]        waddr0;
        logic [WIDTH-1:0]     wdata0;
        logic                 we1;
        logic [AW-1:0]        waddr1;
        logic [WIDTH-1:0]     wdata1;
        logic [1:0]           iss_vld;
        logic [AW-1:0]        iss_rd0;
        logic [AW-1:0]        iss_rd1;
        logic                 flush;
        logic [NRD*AW-1:0]    raddr;
        logic [NRD*WIDTH-1:0] exp_data;
        logic [NRD-1:0]       exp_busy;
    } vec_t;

    vec_t tbl [14];

    regfile_mp #(.WIDTH(WIDTH), .AW(AW), .NRD(NRD)) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_vld(iss_vld), .iss_rd0(iss_rd0), .iss_rd1(iss_rd1), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t row(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic [1:0] iv, input logic [4:0] r0, input logic [4:0] r1,
                                 input logic fl, input logic [19:0] ra, input logic [127:0] ed,
                                 input logic [3:0] eb);
        vec_t v;
        v.we0 = w0; v.waddr0 = a0; v.wdata0 = d0;
        v.we1 = w1; v.waddr1 = a1; v.wdata1 = d1;
        v.iss_vld = iv; v.iss_rd0 = r0; v.iss_rd1 = r1; v.flush = fl;
        v.raddr = ra; v.exp_data = ed; v.exp_busy = eb;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        we0 = v.we0; waddr0 = v.waddr0; wdata0 = v.wdata0;
        we1 = v.we1; waddr1 = v.waddr1; wdata1 = v.wdata1;
        iss_vld = v.iss_vld; iss_rd0 = v.iss_rd0; iss_rd1 = v.iss_rd1;
        flush = v.flush; raddr = v.raddr;
    endtask

    task automatic checkOutput(input string name, input logic [NRD*WIDTH-1:0] ed,
                               input logic [NRD-1:0] eb);
        for (int k = 0; k < NRD; k++) begin
            n_checks++;
            if (rdata[k*WIDTH +: WIDTH] !== ed[k*WIDTH +: WIDTH]) begin
                n_fail++;
                $display("[TB] FAIL %s rdata port %0d: got %h expected %h", name, k,
                         rdata[k*WIDTH +: WIDTH], ed[k*WIDTH +: WIDTH]);
            end
            n_checks++;
            if (rbusy[k] !== eb[k]) begin
                n_fail++;
                $display("[TB] FAIL %s rbusy port %0d: got %b expected %b", name, k,
                         rbusy[k], eb[k]);
            end
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_reg[28] = 32'h00001800;
        m_reg[29] = 32'h00002ffe;
    endtask

    function automatic logic [WIDTH-1:0] modelRead(input int a);
        if (a == 0) return '0;
        if (we1 && int'(waddr1) == a) return wdata1;
        if (we0 && int'(waddr0) == a) return wdata0;
        return m_reg[a];
    endfunction

    function automatic bit modelBusy(input int a);
        if (!SB || a == 0) return 1'b0;
        if ((we0 && int'(waddr0) == a) || (we1 && int'(waddr1) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic modelCommit();
        if (we0 && waddr0 != 0) m_reg[waddr0] = wdata0;
        if (we1 && waddr1 != 0) m_reg[waddr1] = wdata1;
        if (flush) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else begin
            if (we0) m_busy[waddr0] = 1'b0;
            if (we1) m_busy[waddr1] = 1'b0;
            if (iss_vld[0]) m_busy[iss_rd0] = 1'b1;
            if (iss_vld[1]) m_busy[iss_rd1] = 1'b1;
        end
        m_busy[0] = 1'b0;
    endtask

    initial begin
        logic [NRD*WIDTH-1:0] ed;
        logic [NRD-1:0]       eb;
        vec_t                 idle;

        n_checks = 0;
        n_fail   = 0;
        idle = row(0,0,0, 0,0,0, 2'b00,0,0, 0, '0, '0, '0);

        // Rows are in port3..port0 order inside each concatenation.
        tbl[0]  = row(0,0,0, 0,0,0, 2'b00,0,0, 0, {5'd5,5'd29,5'd28,5'd0},
                      {32'h0,32'h00002ffe,32'h00001800,32'h0}, 4'b0000);
        tbl[1]  = row(1,3,32'hDEADBEEF, 0,0,0, 2'b00,0,0, 0, {4{5'd3}}, {4{32'hDEADBEEF}}, 4'b0000);
        tbl[2]  = row(0,0,0, 0,0,0, 2'b00,0,0, 0, {4{5'd3}}, {4{32'hDEADBEEF}}, 4'b0000);
        tbl[3]  = row(1,7,32'h11111111, 1,7,32'h22222222, 2'b00,0,0, 0, {5'd0,5'd3,5'd7,5'd7},
                      {32'h0,32'hDEADBEEF,32'h22222222,32'h22222222}, 4'b0000);
        tbl[4]  = row(1,0,32'hFFFFFFFF, 0,0,0, 2'b00,0,0, 0, {5'd0,5'd0,5'd0,5'd7},
                      {32'h0,32'h0,32'h0,32'h22222222}, 4'b0000);
        tbl[5]  = row(0,0,0, 0,0,0, 2'b01,9,0, 0, {4{5'd9}}, {4{32'h0}}, 4'b0000);
        tbl[6]  = row(0,0,0, 0,0,0, 2'b00,0,0, 0, {4{5'd9}}, {4{32'h0}}, 4'b1111);
        tbl[7]  = row(0,0,0, 1,9,32'h99, 2'b00,0,0, 0, {5'd7,5'd0,5'd9,5'd9},
                      {32'h22222222,32'h0,32'h99,32'h99}, 4'b0000);
        tbl[8]  = row(0,0,0, 0,0,0, 2'b00,0,0, 0, {4{5'd9}}, {4{32'h99}}, 4'b0000);
        tbl[9]  = row(1,9,32'hAA, 0,0,0, 2'b01,9,0, 0, {4{5'd9}}, {4{32'hAA}}, 4'b0000);
        tbl[10] = row(0,0,0, 0,0,0, 2'b00,0,0, 0, {4{5'd9}}, {4{32'hAA}}, 4'b1111);
        tbl[11] = row(0,0,0, 0,0,0, 2'b11,4,5, 0, {5'd9,5'd6,5'd5,5'd4},
                      {32'hAA,32'h0,32'h0,32'h0}, 4'b1000);
        tbl[12] = row(0,0,0, 0,0,0, 2'b01,6,0, 1, {5'd9,5'd6,5'd5,5'd4},
                      {32'hAA,32'h0,32'h0,32'h0}, 4'b1011);
        tbl[13] = row(0,0,0, 0,0,0, 2'b00,0,0, 0, {5'd9,5'd6,5'd5,5'd4},
                      {32'hAA,32'h0,32'h0,32'h0}, 4'b0000);

        rst_n = 1'b0;
        applyStimulus(idle);
        raddr = {5'd3, 5'd29, 5'd28, 5'd0};
        #7;
        checkOutput("in_reset", '0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #1;
            checkOutput($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_busy & {NRD{SB}});
        end

        // Asynchronous reset between edges wipes a committed write.
        @(negedge clk);
        applyStimulus(row(1,10,32'h5, 0,0,0, 2'b01,11,0, 0, {5'd3,5'd28,5'd29,5'd10}, '0, '0));
        @(posedge clk);
        #2;
        applyStimulus(row(0,0,0, 0,0,0, 2'b00,0,0, 0, {5'd3,5'd11,5'd29,5'd10}, '0, '0));
        #1;
        checkOutput("pre_async_rst", {32'hDEADBEEF,32'h0,32'h00002ffe,32'h5}, {1'b0, SB, 2'b00});
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_async_rst", {32'h0,32'h0,32'h00002ffe,32'h0}, '0);
        modelReset();

        for (int n = 0; n < 400; n++) begin
            bit narrow;
            @(negedge clk);
            narrow  = ($urandom_range(0, 1) == 1);
            we0     = $urandom_range(0, 1);
            we1     = $urandom_range(0, 1);
            waddr0  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            waddr1  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wdata0  = $urandom;
            wdata1  = $urandom;
            iss_vld = 2'($urandom);
            iss_rd0 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            iss_rd1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            flush   = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NRD; k++)
                raddr[k*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            for (int k = 0; k < NRD; k++) begin
                ed[k*WIDTH +: WIDTH] = modelRead(int'(raddr[k*AW +: AW]));
                eb[k]                = modelBusy(int'(raddr[k*AW +: AW]));
            end
            #1;
            checkOutput($sformatf("rand%0d", n), ed, eb);
            modelCommit();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
